ping_pong_buffer: RTL

Double-banked word buffer between the JTAG shift/command logic and the DMA engine. The JTAG side fills or drains one bank while the DMA side (pp_* port) works on the other. A request/busy handshake swaps the banks only when the DMA is idle. On each swap the JTAG fill level is handed to the DMA side so the DMA knows how many words are valid.

---
 rtl/jtag_pkg.sv | 15 +
 rtl/pp_bank_ram.sv | 40 ++++
 rtl/ping_pong_buffer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG <-> DMA ping-pong buffer.
//   DEFAULT_ADDR_WIDTH / DEFAULT_DATA_WIDTH : default bank geometry
//   swapState_t                             : bank-swap FSM states
package jtag_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 9;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2
  } swapState_t;

endpackage

// File: rtl/pp_bank_ram.sv
// One bank of the ping-pong buffer: single-clock RAM with one write port and
// one registered read port sharing a single address.
//   clock, n_reset : system clock, async active-low reset (read register only)
//   writeEnable    : write strobe, data stored at the rising edge
//   address        : word address for both the write and the read
//   dataIn         : write data
//   dataOut        : registered read data, read-first (old word on a write)
module pp_bank_ram
  import jtag_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  n_reset,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [DATA_WIDTH-1:0] dataOut
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  // Storage is never reset; only the read register is.
  always_ff @(posedge clock) begin
    if (writeEnable) begin
      mem[address] <= dataIn;
    end
  end

  // Samples the array before this edge's write lands, hence read-first.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      dataOut <= '0;
    end else begin
      dataOut <= mem[address];
    end
  end

endmodule

// File: rtl/ping_pong_buffer.sv
// Double-banked word buffer between the JTAG shift/command logic and the DMA
// engine. JTAG owns bank bankSel, the DMA owns the other one; a swap flips
// ownership and hands the JTAG fill level over to the DMA side.
//   clock, n_reset                          : system clock, async active-low reset
//   jtag_address/dataIn/writeEnable/dataOut : JTAG-side bank access
//   jtag_switch_req                         : one-cycle swap request
//   switch_pending                          : request held, waiting for DMA idle
//   switch_done                             : one-cycle pulse after the swap edge
//   jtag_bank                               : bank currently owned by JTAG
//   pp_address/dataIn/writeEnable/dataOut   : DMA-side bank access
//   dma_busy                                : DMA engine busy, blocks a swap
//   dma_fill_level                          : valid words in the DMA bank
//
// Swap handshake: jtag_switch_req is a single-cycle pulse sampled in IDLE only.
// The swap edge is the end of the one-cycle SWAP state, which is entered on an
// edge where dma_busy is sampled low. dma_busy is not looked at once in SWAP, so
// the DMA must wait for switch_done before raising busy on the new bank.
module ping_pong_buffer
  import jtag_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  n_reset,
  input  logic [ADDR_WIDTH-1:0] jtag_address,
  input  logic [DATA_WIDTH-1:0] jtag_dataIn,
  input  logic                  jtag_writeEnable,
  output logic [DATA_WIDTH-1:0] jtag_dataOut,
  input  logic                  jtag_switch_req,
  output logic                  switch_pending,
  output logic                  switch_done,
  output logic                  jtag_bank,
  input  logic [ADDR_WIDTH-1:0] pp_address,
  input  logic [DATA_WIDTH-1:0] pp_dataIn,
  input  logic                  pp_writeEnable,
  output logic [DATA_WIDTH-1:0] pp_dataOut,
  input  logic                  dma_busy,
  output logic [ADDR_WIDTH:0]   dma_fill_level
);

  swapState_t            state;
  swapState_t            stateNext;
  logic                  swapNow;
  logic                  bankSel;
  logic                  readBankSel;
  logic [ADDR_WIDTH:0]   jtagFill;
  logic [ADDR_WIDTH:0]   fillNext;
  logic [ADDR_WIDTH:0]   jtagAddrPlusOne;

  logic                  bank0We;
  logic                  bank1We;
  logic [ADDR_WIDTH-1:0] bank0Addr;
  logic [ADDR_WIDTH-1:0] bank1Addr;
  logic [DATA_WIDTH-1:0] bank0Din;
  logic [DATA_WIDTH-1:0] bank1Din;
  logic [DATA_WIDTH-1:0] bank0Dout;
  logic [DATA_WIDTH-1:0] bank1Dout;

  assign jtag_bank = bankSel;

  // Port steering: bank0 belongs to JTAG when bankSel=0, to the DMA otherwise.
  assign bank0We   = bankSel ? pp_writeEnable : jtag_writeEnable;
  assign bank0Addr = bankSel ? pp_address     : jtag_address;
  assign bank0Din  = bankSel ? pp_dataIn      : jtag_dataIn;
  assign bank1We   = bankSel ? jtag_writeEnable : pp_writeEnable;
  assign bank1Addr = bankSel ? jtag_address     : pp_address;
  assign bank1Din  = bankSel ? jtag_dataIn      : pp_dataIn;

  pp_bank_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank0 (
    .clock       (clock),
    .n_reset     (n_reset),
    .writeEnable (bank0We),
    .address     (bank0Addr),
    .dataIn      (bank0Din),
    .dataOut     (bank0Dout)
  );

  pp_bank_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank1 (
    .clock       (clock),
    .n_reset     (n_reset),
    .writeEnable (bank1We),
    .address     (bank1Addr),
    .dataIn      (bank1Din),
    .dataOut     (bank1Dout)
  );

  // Read data is routed by the ownership that held at the read's address edge,
  // so a read straddling the swap edge still comes from the bank it addressed.
  assign jtag_dataOut = readBankSel ? bank1Dout : bank0Dout;
  assign pp_dataOut   = readBankSel ? bank0Dout : bank1Dout;

  // Fill level is the highest written address plus one, so it can reach 2^ADDR_WIDTH.
  assign jtagAddrPlusOne = {1'b0, jtag_address} + {{ADDR_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    fillNext = jtagFill;
    if (jtag_writeEnable && (jtagAddrPlusOne > jtagFill)) begin
      fillNext = jtagAddrPlusOne;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext      = state;
    switch_pending = 1'b0;
    swapNow        = 1'b0;
    case (state)
      IDLE: begin
        if (jtag_switch_req) begin
          stateNext = dma_busy ? PENDING : SWAP;
        end
      end
      PENDING: begin
        switch_pending = 1'b1;
        if (!dma_busy) begin
          stateNext = SWAP;
        end
      end
      SWAP: begin
        swapNow   = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // A JTAG write in the SWAP cycle is folded in via fillNext before handover.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      bankSel        <= 1'b0;
      readBankSel    <= 1'b0;
      jtagFill       <= '0;
      dma_fill_level <= '0;
      switch_done    <= 1'b0;
    end else begin
      readBankSel <= bankSel;
      switch_done <= swapNow;
      if (swapNow) begin
        bankSel        <= ~bankSel;
        dma_fill_level <= fillNext;
        jtagFill       <= '0;
      end else begin
        jtagFill <= fillNext;
      end
    end
  end

endmodule
